cram_bridge: RTL and testbench

Cart-RAM access sequencer sitting directly downstream of the cartridge mapper's `cram_*` port. It posts mapper-generated writes into a small queue and fetches read data on CPU read strobes. It arbitrates both onto a single request/acknowledge memory port in program order, and returns read data to the mapper on `cram_di`. It also tracks unsaved writes for battery-save logic.

---
 rtl/cram_bridge.sv | 179 +++++++++++++++++
 tb/tb_cram_bridge.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_bridge.sv
// cram_bridge: queues mapper cart-RAM writes and fetches CPU reads over one req/ack memory port, in program order.
// Define CRAM_DIRTY_EN to build the battery-save dirty flag (sav_dirty / sav_clear).
module cram_bridge #(
    parameter int WQ_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic [3:0]  ram_mask,
    input  logic [16:0] cram_addr,
    input  logic        cram_wr,
    input  logic [7:0]  cram_wr_do,
    input  logic        cram_rd,
    output logic [7:0]  cram_di,
    output logic        rd_busy,
    output logic        wq_full,
    output logic        wr_overflow,
    output logic        mem_req,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        sav_clear,
    output logic        sav_dirty
);

    localparam int PW = $clog2(WQ_DEPTH);
    localparam int CW = $clog2(WQ_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

    state_t        state;

    logic [16:0]   wq_addr [WQ_DEPTH];
    logic [7:0]    wq_data [WQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] wq_count;

    logic          rd_prev;
    logic          rd_pending;
    logic [16:0]   rd_addr;

    logic [16:0]   masked_addr;
    logic          wr_strobe;
    logic          wr_push;
    logic          wr_pop;
    logic          rd_edge;
    logic          rd_issue;

    assign masked_addr = {cram_addr[16:13] & ram_mask, cram_addr[12:0]};
    assign wr_strobe   = ce_cpu & cram_wr;
    assign wr_push     = wr_strobe & ~wq_full;
    assign wr_pop      = (state == WR) & mem_ack;
    assign rd_edge     = ce_cpu & cram_rd & ~rd_prev;
    assign rd_issue    = (state == IDLE) && (wq_count == '0) && rd_pending;

    assign wq_full     = (wq_count == CW'(WQ_DEPTH));
    assign rd_busy     = rd_pending | (state == RD);

    // Queue storage carries no reset; entries are only read once counted valid.
    always_ff @(posedge clk_sys) begin
        if (wr_push) begin
            wq_addr[wr_ptr] <= masked_addr;
            wq_data[wr_ptr] <= cram_wr_do;
        end
    end

    // Full is judged on the registered count, so a pop in the same cycle cannot rescue a push.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wq_count    <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (wr_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            wq_count <= wq_count + CW'(wr_push) - CW'(wr_pop);
            if (wr_strobe && wq_full) begin
                wr_overflow <= 1'b1;
            end
        end
    end

    // An edge arriving in the issue cycle or during an in-flight read re-arms the slot.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_prev    <= 1'b0;
            rd_pending <= 1'b0;
            rd_addr    <= '0;
        end else begin
            if (ce_cpu) begin
                rd_prev <= cram_rd;
            end
            if (rd_issue) begin
                rd_pending <= 1'b0;
            end
            if (rd_edge) begin
                rd_pending <= 1'b1;
                rd_addr    <= masked_addr;
            end
        end
    end

    // Writes win in IDLE so a read never overtakes an earlier queued write.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cram_di   <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    if (wq_count != '0) begin
                        state     <= WR;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wq_addr[rd_ptr];
                        mem_wdata <= wq_data[rd_ptr];
                    end else if (rd_pending) begin
                        state    <= RD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= rd_addr;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        cram_di <= mem_rdata;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRAM_DIRTY_EN
    // A write landing in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sav_dirty <= 1'b0;
        end else if (wr_pop) begin
            sav_dirty <= 1'b1;
        end else if (sav_clear) begin
            sav_dirty <= 1'b0;
        end
    end
`else
    logic unused_sav_clear;

    assign unused_sav_clear = sav_clear;
    assign sav_dirty        = 1'b0;
`endif

endmodule

// File: tb/tb_cram_bridge.sv
// Scoreboard bench for cram_bridge: directed scenarios plus randomized traffic checked against
// a byte-addressed reference memory; a monitor pops expected transactions as the DUT issues them.
`timescale 1ns/1ps
module tb_cram_bridge;

    localparam int WQ_DEPTH = 4;
    localparam int CLK_HALF = 5;

`ifdef CRAM_DIRTY_EN
    localparam logic DIRTY_BUILD = 1'b1;
`else
    localparam logic DIRTY_BUILD = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_cpu;
    logic [3:0]  ram_mask;
    logic [16:0] cram_addr;
    logic        cram_wr;
    logic [7:0]  cram_wr_do;
    logic        cram_rd;
    logic [7:0]  cram_di;
    logic        rd_busy;
    logic        wq_full;
    logic        wr_overflow;
    logic        mem_req;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        sav_clear;
    logic        sav_dirty;

    cram_bridge #(.WQ_DEPTH(WQ_DEPTH)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_cpu      (ce_cpu),
        .ram_mask    (ram_mask),
        .cram_addr   (cram_addr),
        .cram_wr     (cram_wr),
        .cram_wr_do  (cram_wr_do),
        .cram_rd     (cram_rd),
        .cram_di     (cram_di),
        .rd_busy     (rd_busy),
        .wq_full     (wq_full),
        .wr_overflow (wr_overflow),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .sav_clear   (sav_clear),
        .sav_dirty   (sav_dirty)
    );

    always #CLK_HALF clk_sys = ~clk_sys;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  data;
        logic        busy_after;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] ref_mem [int];
    logic [7:0] mem_array [int];

    int errors = 0;
    int checks = 0;

    // Shared test-side state: stimulus owns these, the memory responder only reads them.
    int   min_wait = 0;
    int   max_wait = 0;
    bit   mem_hold = 1'b0;
    int   late_ack_req = 0;
    int   accepted_wr = 0;
    int   wr_base = 0;
    logic exp_overflow = 1'b0;

    // Responder-owned state.
    bit   in_txn = 1'b0;
    int   wait_left = 0;
    bit   ack_was_write = 1'b0;
    int   wr_done = 0;
    int   late_ack_done = 0;

    bit   mon_active = 1'b0;

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37) ^ (a >> 5) ^ 8'h5C);
    endfunction

    // Bank index is the 8 KB page number; only the banks enabled by the mask survive.
    function automatic logic [16:0] model_mask(input logic [16:0] a, input logic [3:0] m);
        int bank;
        int off;
        bank = int'(a) / 8192;
        off  = int'(a) % 8192;
        return 17'((bank & int'(m)) * 8192 + off);
    endfunction

    function automatic logic [7:0] ref_read(input logic [16:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_byte(int'(a));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
        #2;
    endtask

    task automatic applyStimulus(input bit is_write, input logic [16:0] addr, input logic [7:0] data,
                                 input logic [3:0] mask, input bit busy_after);
        txn_t t;
        ram_mask     = mask;
        cram_addr    = addr;
        t.we         = is_write;
        t.addr       = model_mask(addr, mask);
        t.busy_after = busy_after;
        if (is_write) begin
            cram_wr_do = data;
            cram_wr    = 1'b1;
            if (accepted_wr - (wr_done - wr_base) < WQ_DEPTH) begin
                t.data = data;
                ref_mem[int'(t.addr)] = data;
                exp_q.push_back(t);
                accepted_wr++;
            end else begin
                exp_overflow = 1'b1;
            end
            step();
            cram_wr = 1'b0;
        end else begin
            t.data = ref_read(t.addr);
            exp_q.push_back(t);
            cram_rd = 1'b1;
            step();
            cram_rd = 1'b0;
            step();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 300) begin
            step();
            n++;
        end
        checkOutput("drain_pending", 32'(exp_q.size()) + 32'(mon_active), 32'h0);
        exp_q.delete();
    endtask

    // Memory responder: acks each request after a random wait and keeps its own storage.
    always @(negedge clk_sys) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            in_txn  = 1'b0;
            if (ack_was_write) wr_done++;
        end
        if (reset) begin
            in_txn = 1'b0;
        end else if (late_ack_req != late_ack_done) begin
            late_ack_done = late_ack_req;
            ack_was_write = 1'b0;
            mem_rdata     = 8'h3C;
            mem_ack       = 1'b1;
        end else begin
            if (mem_req && !in_txn) begin
                in_txn    = 1'b1;
                wait_left = $urandom_range(max_wait, min_wait);
            end
            if (in_txn && !mem_hold) begin
                if (wait_left == 0) begin
                    mem_ack       = 1'b1;
                    ack_was_write = mem_we;
                    if (mem_we) begin
                        mem_array[int'(mem_addr)] = mem_wdata;
                    end else if (mem_array.exists(int'(mem_addr))) begin
                        mem_rdata = mem_array[int'(mem_addr)];
                    end else begin
                        mem_rdata = init_byte(int'(mem_addr));
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Monitor: matches each new request against the scoreboard and checks results on completion.
    txn_t        cur;
    logic [25:0] snap;
    always @(negedge clk_sys) begin
        #1;
        if (reset) begin
            mon_active = 1'b0;
        end else if (mem_req) begin
            if (!mon_active) begin
                mon_active = 1'b1;
                snap = {mem_we, mem_addr, mem_wdata};
                checkOutput("req_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    checkOutput("mem_we", 32'(mem_we), 32'(cur.we));
                    checkOutput("mem_addr", 32'(mem_addr), 32'(cur.addr));
                    if (cur.we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(cur.data));
                end else begin
                    cur.we         = 1'b1;
                    cur.addr       = mem_addr;
                    cur.data       = mem_wdata;
                    cur.busy_after = 1'b0;
                end
            end else begin
                checkOutput("req_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(snap));
            end
        end else if (mon_active) begin
            mon_active = 1'b0;
            if (cur.we) begin
                checkOutput("sav_dirty_after_wr", 32'(sav_dirty), 32'(DIRTY_BUILD));
            end else begin
                checkOutput("cram_di", 32'(cram_di), 32'(cur.data));
                checkOutput("rd_busy_after_rd", 32'(rd_busy), 32'(cur.busy_after));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset      = 1'b1;
        ce_cpu     = 1'b1;
        ram_mask   = 4'hF;
        cram_addr  = '0;
        cram_wr    = 1'b0;
        cram_wr_do = '0;
        cram_rd    = 1'b0;
        sav_clear  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        $display("[TB] reset values");
        checkOutput("rst_cram_di", 32'(cram_di), 32'hFF);
        checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("rst_rd_busy", 32'(rd_busy), 32'h0);
        checkOutput("rst_wq_full", 32'(wq_full), 32'h0);
        checkOutput("rst_wr_overflow", 32'(wr_overflow), 32'h0);
        checkOutput("rst_sav_dirty", 32'(sav_dirty), 32'h0);

        $display("[TB] single write");
        applyStimulus(1'b1, 17'h00123, 8'h5A, 4'hF, 1'b0);
        checkOutput("wr_req_after_e0", 32'(mem_req), 32'h0);
        @(posedge clk_sys);
        #1;
        checkOutput("wr_req_after_e1", 32'(mem_req), 32'h1);
        drain();
        checkOutput("single_sav_dirty", 32'(sav_dirty), 32'(DIRTY_BUILD));

        $display("[TB] overflow");
        mem_hold = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 17'(17'h00200 + i), 8'(8'h10 + i), 4'hF, 1'b0);
        checkOutput("wq_full_after_3", 32'(wq_full), 32'h0);
        applyStimulus(1'b1, 17'h00203, 8'h13, 4'hF, 1'b0);
        checkOutput("wq_full_after_4", 32'(wq_full), 32'h1);
        checkOutput("overflow_after_4", 32'(wr_overflow), 32'h0);
        applyStimulus(1'b1, 17'h00204, 8'h14, 4'hF, 1'b0);
        checkOutput("overflow_after_5", 32'(wr_overflow), 32'(exp_overflow));
        mem_hold = 1'b0;
        drain();
        checkOutput("wq_full_drained", 32'(wq_full), 32'h0);

        $display("[TB] read after write");
        min_wait = 3;
        max_wait = 3;
        applyStimulus(1'b1, 17'h00010, 8'hC3, 4'hF, 1'b0);
        applyStimulus(1'b0, 17'h00010, 8'h00, 4'hF, 1'b0);
        checkOutput("raw_rd_busy_pending", 32'(rd_busy), 32'h1);
        drain();
        checkOutput("raw_cram_di", 32'(cram_di), 32'hC3);
        checkOutput("raw_rd_busy_done", 32'(rd_busy), 32'h0);

        $display("[TB] masking");
        applyStimulus(1'b1, 17'h0E000, 8'h77, 4'h1, 1'b0);
        drain();

        $display("[TB] read re-arm");
        applyStimulus(1'b0, 17'h00001, 8'h00, 4'hF, 1'b1);
        applyStimulus(1'b0, 17'h00002, 8'h00, 4'hF, 1'b0);
        drain();
        checkOutput("rearm_cram_di", 32'(cram_di), 32'(ref_read(17'h00002)));

        $display("[TB] save flag");
        sav_clear = 1'b1;
        step();
        sav_clear = 1'b0;
        checkOutput("sav_cleared", 32'(sav_dirty), 32'h0);
        min_wait = 0;
        max_wait = 0;
        sav_clear = 1'b1;
        applyStimulus(1'b1, 17'h00300, 8'h99, 4'hF, 1'b0);
        drain();
        sav_clear = 1'b0;
        checkOutput("sav_set_wins", 32'(sav_dirty), 32'(DIRTY_BUILD));

        $display("[TB] randomized traffic");
        max_wait = 2;
        for (int i = 0; i < 150; i++) begin
            int          r;
            logic [16:0] a;
            logic [3:0]  m;
            r = $urandom_range(9, 0);
            a = 17'($urandom_range(7, 0) * 8192 + $urandom_range(15, 0));
            m = 4'($urandom_range(15, 0));
            if (r < 6) begin
                if ($urandom_range(7, 0) == 0) begin
                    ce_cpu     = 1'b0;
                    ram_mask   = m;
                    cram_addr  = a;
                    cram_wr_do = 8'($urandom);
                    cram_wr    = 1'b1;
                    step();
                    cram_wr = 1'b0;
                    ce_cpu  = 1'b1;
                end else begin
                    applyStimulus(1'b1, a, 8'($urandom), m, 1'b0);
                end
            end else if (r < 8) begin
                applyStimulus(1'b0, a, 8'h00, m, 1'b0);
                drain();
            end else begin
                step();
            end
        end
        drain();
        checkOutput("rand_overflow", 32'(wr_overflow), 32'(exp_overflow));
        checkOutput("rand_rd_busy", 32'(rd_busy), 32'h0);

        $display("[TB] reset mid-read");
        mem_hold = 1'b1;
        min_wait = 0;
        max_wait = 0;
        applyStimulus(1'b0, 17'h00123, 8'h00, 4'hF, 1'b0);
        checkOutput("rst_mid_req_before", 32'(mem_req), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_mid_cram_di", 32'(cram_di), 32'hFF);
        checkOutput("rst_mid_rd_busy", 32'(rd_busy), 32'h0);
        step();
        exp_q.delete();
        accepted_wr  = 0;
        wr_base      = wr_done;
        exp_overflow = 1'b0;
        reset        = 1'b0;
        mem_hold     = 1'b0;
        late_ack_req++;
        step();
        step();
        checkOutput("late_ack_cram_di", 32'(cram_di), 32'hFF);
        checkOutput("late_ack_rd_busy", 32'(rd_busy), 32'h0);
        checkOutput("late_ack_mem_req", 32'(mem_req), 32'h0);
        checkOutput("late_ack_overflow", 32'(wr_overflow), 32'(exp_overflow));
        checkOutput("late_ack_sav_dirty", 32'(sav_dirty), 32'h0);

        applyStimulus(1'b1, 17'h00055, 8'hAB, 4'hF, 1'b0);
        applyStimulus(1'b0, 17'h00055, 8'h00, 4'hF, 1'b0);
        drain();
        checkOutput("post_rst_cram_di", 32'(cram_di), 32'hAB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
